// File: rtl/accumulator_pkg.sv
// Shared types and width helpers for the accumulator scheduler and the accumulator it drives.
package accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        FLUSH = 2'd2,
        OUT   = 2'd3
    } sched_state_e;

    // Res_depth width; a single-stage chain still carries a 1-bit (always 0) bus.
    function automatic int dctl_w(input int depth);
        return (depth == 1) ? 1 : depth - 1;
    endfunction

    function automatic int dsel_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic logic [31:0] depth_therm(input logic [31:0] dsel);
        return (32'd1 << dsel) - 32'd1;
    endfunction

endpackage

// File: rtl/accumulator_sched_beat_counter.sv
// Loadable down-counter with a zero flag; counts job beats and flush cycles.
module beat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Contents are only meaningful after a load, so no reset is needed.
    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/accumulator_sched.sv
// Job sequencer for one feedback accumulator: load/accumulate K beats, flush to the tap, hold result.
module accumulator_sched
    import accumulator_pkg::*;
#(
    parameter  int DEPTH  = 1,
    parameter  int LEN_W  = 16,
    localparam int DCTL_W = dctl_w(DEPTH),
    localparam int DSEL_W = dsel_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DSEL_W-1:0] cmd_depth,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              Res_en,
    output logic              Res_mode,
    output logic [DCTL_W-1:0] Res_depth,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic [15:0]       jobs_done
);

    localparam logic [DSEL_W-1:0] DSEL_MAX = DSEL_W'(DEPTH - 1);

    sched_state_e      state_q, state_d;
    logic [DSEL_W-1:0] dsel_q, dsel_sat;
    logic              first_q;
    logic [15:0]       jobs_q;

    logic latch_cmd, beat_acc, flush_load, flush_dec, done_inc;
    logic beat_last, flush_last;

    assign dsel_sat = (cmd_depth > DSEL_MAX) ? DSEL_MAX : cmd_depth;

    beat_counter #(.W(LEN_W)) u_beat_cnt (
        .clk_i      (clk),
        .load_i     (latch_cmd),
        .load_val_i (cmd_len),
        .dec_i      (beat_acc),
        .zero_o     (beat_last)
    );

    // Loaded with dsel-1 so the zero flag marks the final flush cycle.
    beat_counter #(.W(DSEL_W)) u_flush_cnt (
        .clk_i      (clk),
        .load_i     (flush_load),
        .load_val_i (dsel_q - DSEL_W'(1)),
        .dec_i      (flush_dec),
        .zero_o     (flush_last)
    );

    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        in_ready   = 1'b0;
        Res_en     = 1'b0;
        Res_mode   = 1'b0;
        res_valid  = 1'b0;
        latch_cmd  = 1'b0;
        beat_acc   = 1'b0;
        flush_load = 1'b0;
        flush_dec  = 1'b0;
        done_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    latch_cmd = 1'b1;
                    state_d   = ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                Res_en   = in_valid;
                if (in_valid) begin
                    beat_acc = 1'b1;
                    Res_mode = ~first_q;
                    if (beat_last) begin
                        if (dsel_q != '0) begin
                            flush_load = 1'b1;
                            state_d    = FLUSH;
                        end else begin
                            state_d = OUT;
                        end
                    end
                end
            end
            FLUSH: begin
                Res_en    = 1'b1;
                flush_dec = 1'b1;
                if (flush_last) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    done_inc  = 1'b1;
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        latch_cmd = 1'b1;
                        state_d   = ACC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dsel_q  <= '0;
            first_q <= 1'b0;
            jobs_q  <= '0;
        end else begin
            state_q <= state_d;
            if (latch_cmd) begin
                dsel_q  <= dsel_sat;
                first_q <= 1'b1;
            end else if (beat_acc) begin
                first_q <= 1'b0;
            end
            if (done_inc) begin
                jobs_q <= jobs_q + 16'd1;
            end
        end
    end

    assign Res_depth = DCTL_W'(depth_therm(32'(dsel_q)));
    assign busy      = (state_q != IDLE);
    assign jobs_done = jobs_q;

endmodule

// File: tb/tb_accumulator_sched.sv
// Bench for accumulator_sched: directed table, corner sequences and randomized jobs checked by a sum model.
module tb_accumulator_sched;

    localparam int DEPTH = 5;
    localparam int LEN_W = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_len = '0;
    logic [2:0] cmd_depth = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       Res_en;
    logic       Res_mode;
    logic [3:0] Res_depth;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic       busy;
    logic [15:0] jobs_done;

    accumulator_sched #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_depth (cmd_depth),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Res_en    (Res_en),
        .Res_mode  (Res_mode),
        .Res_depth (Res_depth),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .jobs_done (jobs_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int jobs_exp = 0;
    int mult = 0;
    int res_in = 0;
    int beats [16];
    logic [31:0] gap_pat = '0;

    // Behavioural delay-chain accumulator driven by the scheduler's controls.
    int acc [0:DEPTH-1];
    always @(posedge clk) begin
        if (Res_en) begin
            acc[0] <= Res_mode ? acc[0] + mult : res_in + mult;
            for (int i = 1; i < DEPTH; i++) acc[i] <= acc[i-1];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_cmd(input int len, input int depth, input int rin);
        cmd_valid = 1'b1;
        cmd_len   = 4'(len);
        cmd_depth = 3'(depth);
        res_in    = rin;
        #1;
        chk("cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // mode 0: solid in_valid, 1: random gaps, 2: gap_pat
    task automatic do_beats(input int len, input int mode, input logic [3:0] therm);
        int nb = 0;
        int cyc = 0;
        while (nb <= len && cyc < 400) begin
            case (mode)
                1:       in_valid = 1'($urandom_range(0, 1));
                2:       in_valid = gap_pat[cyc % 32];
                default: in_valid = 1'b1;
            endcase
            mult = beats[nb];
            #1;
            chk("acc_in_ready", in_ready, 1);
            chk("acc_res_en", Res_en, in_valid);
            chk("acc_depth", Res_depth, therm);
            if (in_valid) begin
                chk("acc_mode", Res_mode, (nb != 0) ? 1 : 0);
                nb++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        mult = 0;
        if (nb <= len) chk("beat_timeout", nb, len + 1);
    endtask

    task automatic finish_job(input int dsel, input int exp_sum, input int hold, input int rel);
        int fc = 0;
        while (fc < 40) begin
            #1;
            if (res_valid) break;
            chk("flush_en", Res_en, 1);
            chk("flush_mode", Res_mode, 0);
            chk("flush_in_ready", in_ready, 0);
            fc++;
            @(negedge clk);
        end
        chk("flush_cycles", fc, dsel);
        chk("out_valid", res_valid, 1);
        chk("out_res_en", Res_en, 0);
        chk("out_sum", acc[dsel], exp_sum);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            chk("hold_valid", res_valid, 1);
            chk("hold_sum", acc[dsel], exp_sum);
            chk("hold_jobs", jobs_done, jobs_exp);
        end
        if (rel != 0) begin
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            jobs_exp++;
            #1;
            chk("rel_jobs", jobs_done, jobs_exp);
            chk("rel_valid", res_valid, 0);
            chk("rel_busy", busy, 0);
        end
    endtask

    task automatic run_job(input int len, input int depth, input int rin, input int mode,
                           input int hold, input int exp_sum, input int dsel,
                           input logic [3:0] therm);
        send_cmd(len, depth, rin);
        do_beats(len, mode, therm);
        finish_job(dsel, exp_sum, hold, 1);
    endtask

    typedef struct {
        int len; int depth; int rin;
        int b0; int b1; int b2; int b3;
        int mode; int hold;
        int exp_sum; int exp_dsel; logic [3:0] exp_therm;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int sum, dsel, len, depth, rin, mode;
        logic [3:0] therm;

        vecs[0] = '{3, 0,    0,  5,  6, 7, 8, 0, 0,  26, 0, 4'b0000};
        vecs[1] = '{1, 2,    0, 10, -3, 0, 0, 0, 5,   7, 2, 4'b0011};
        vecs[2] = '{2, 0,    0,  1,  2, 3, 0, 2, 0,   6, 0, 4'b0000};
        vecs[3] = '{2, 7,    0,  1,  2, 3, 0, 0, 1,   6, 4, 4'b1111};
        vecs[4] = '{0, 4,   -5,  3,  0, 0, 0, 0, 0,  -2, 4, 4'b1111};
        vecs[5] = '{3, 1,  100,  1,  1, 1, 1, 1, 2, 104, 1, 4'b0001};
        gap_pat = 32'b11001;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_res_en", Res_en, 0);
        chk("rst_res_mode", Res_mode, 0);
        chk("rst_res_depth", Res_depth, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_jobs", jobs_done, 0);
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            beats[0] = vecs[v].b0; beats[1] = vecs[v].b1;
            beats[2] = vecs[v].b2; beats[3] = vecs[v].b3;
            run_job(vecs[v].len, vecs[v].depth, vecs[v].rin, vecs[v].mode, vecs[v].hold,
                    vecs[v].exp_sum, vecs[v].exp_dsel, vecs[v].exp_therm);
        end

        // in_valid and res_ready while idle are ignored
        in_valid = 1'b1;
        res_ready = 1'b1;
        #1;
        chk("idle_res_en", Res_en, 0);
        chk("idle_in_ready", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        res_ready = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_jobs", jobs_done, jobs_exp);
        chk("idle_valid", res_valid, 0);

        // back-to-back: new command accepted in the same cycle the result is taken
        beats[0] = 20; beats[1] = 22;
        send_cmd(1, 0, 0);
        do_beats(1, 0, 4'b0000);
        finish_job(0, 42, 1, 0);
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_len   = 4'd0;
        cmd_depth = 3'd0;
        #1;
        chk("b2b_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        res_in = 4;
        jobs_exp++;
        #1;
        chk("b2b_jobs", jobs_done, jobs_exp);
        chk("b2b_in_ready", in_ready, 1);
        chk("b2b_valid", res_valid, 0);
        beats[0] = 9;
        do_beats(0, 0, 4'b0000);
        finish_job(0, 13, 0, 1);

        // reset in the middle of accumulation abandons the job
        beats[0] = 1; beats[1] = 2; beats[2] = 3; beats[3] = 4;
        send_cmd(3, 2, 0);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            mult = beats[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        jobs_exp = 0;
        #1;
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_res_en", Res_en, 0);
        chk("mid_rst_depth", Res_depth, 0);
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_jobs", jobs_done, 0);
        @(negedge clk);
        #1;
        chk("mid_rst_no_valid", res_valid, 0);
        @(negedge clk);
        beats[0] = 7; beats[1] = 8;
        run_job(1, 3, 1, 0, 0, 16, 3, 4'b0111);

        // longest job: 2^LEN_W beats
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            beats[i] = int'($urandom_range(0, 60)) - 30;
            sum += beats[i];
        end
        run_job(15, 1, 0, 1, 0, sum, 1, 4'b0001);

        // randomized jobs against plain arithmetic
        for (int j = 0; j < 25; j++) begin
            len   = int'($urandom_range(0, 15));
            depth = int'($urandom_range(0, 7));
            rin   = int'($urandom_range(0, 200)) - 100;
            mode  = int'($urandom_range(0, 1));
            sum   = rin;
            for (int i = 0; i <= len; i++) begin
                beats[i] = int'($urandom_range(0, 200)) - 100;
                sum += beats[i];
            end
            dsel  = (depth > DEPTH - 1) ? DEPTH - 1 : depth;
            therm = 4'((1 << dsel) - 1);
            run_job(len, depth, rin, mode, int'($urandom_range(0, 2)), sum, dsel, therm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
